// File: rtl/tog_sync_src.sv
// Source-side launcher for a toggle synchronizer: registers one word, strobes pulse_out,
// and holds the word until the far side acknowledges or a timeout expires.
module tog_sync_src #(
  parameter int unsigned N           = 8,
  parameter int unsigned HOLD_CYCLES = 6,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic         clkA,
  input  logic         rst_n,
  input  logic         enaA,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] data_out,
  output logic         pulse_out,
  input  logic         ack_in,
  output logic         busy,
  output logic         err_timeout,
  output logic [7:0]   xfer_count
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HoldLast    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [7:0]    xfer_q, xfer_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_seen_q, ack_seen_d;

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      xfer_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      xfer_q     <= xfer_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    xfer_d     = xfer_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    ack_seen_d = ack_seen_q;
    if (enaA) begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_d  = in_data;
            xfer_d  = xfer_q + 8'd1;
            state_d = StLaunch;
          end
        end
        StLaunch: begin
          state_d    = StWait;
          cnt_d      = '0;
          ack_seen_d = 1'b0;
        end
        StWait: begin
          // An ack coinciding with the last timeout cycle takes priority over the error.
          if ((ack_in || ack_seen_q) && (cnt_q >= HoldLast)) begin
            state_d = StIdle;
          end else if (cnt_q == TimeoutLast) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            cnt_d      = cnt_q + CW'(1);
            ack_seen_d = ack_seen_q | ack_in;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready    = enaA && (state_q == StIdle);
    pulse_out   = (state_q == StLaunch);
    busy        = (state_q != StIdle);
    data_out    = data_q;
    err_timeout = err_q;
    xfer_count  = xfer_q;
  end

endmodule

// File: tb/tb_tog_sync_src.sv
// Directed bench for tog_sync_src: hold, early ack, timeout, enable freeze, back-to-back,
// asynchronous reset and the ack/timeout tie.
module tb_tog_sync_src;

  logic       clkA = 1'b0;
  logic       rst_n = 1'b0;
  logic       enaA = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] data_out;
  logic       pulse_out;
  logic       ack_in = 1'b0;
  logic       busy;
  logic       err_timeout;
  logic [7:0] xfer_count;

  int errors = 0;
  int checks = 0;

  tog_sync_src #(.N(8), .HOLD_CYCLES(6), .TIMEOUT(64)) dut (
    .clkA       (clkA),
    .rst_n      (rst_n),
    .enaA       (enaA),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .pulse_out  (pulse_out),
    .ack_in     (ack_in),
    .busy       (busy),
    .err_timeout(err_timeout),
    .xfer_count (xfer_count)
  );

  always #5 clkA = ~clkA;

  task automatic step();
    @(posedge clkA);
    #1;
  endtask

  // Launch one word from IDLE; returns in WAIT cycle 0.
  task automatic send(input logic [7:0] d, input logic [7:0] exp_cnt);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL send_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    checks++;
    if (pulse_out !== 1'b1 || data_out !== d || in_ready !== 1'b0 || xfer_count !== exp_cnt) begin
      errors++;
      $display("FAIL launch: pulse=%b data=%h ready=%b cnt=%0d, required 1 %h 0 %0d",
               pulse_out, data_out, in_ready, xfer_count, d, exp_cnt);
    end
    step();
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pulse_one_cycle: pulse=%b busy=%b, required 0 1", pulse_out, busy);
    end
  endtask

  // Steps n WAIT cycles, each required to still be busy with the word held.
  task automatic hold_cycles(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (busy !== 1'b1 || data_out !== d || pulse_out !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: busy=%b data=%h pulse=%b ready=%b, required 1 %h 0 0",
                 i, busy, data_out, pulse_out, in_ready, d);
      end
      step();
    end
  endtask

  task automatic ack_step();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if (data_out !== 8'h00 || pulse_out !== 1'b0 || busy !== 1'b0 || xfer_count !== 8'd0 ||
        err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: data=%h pulse=%b busy=%b cnt=%0d err=%b, required 00 0 0 0 0",
               data_out, pulse_out, busy, xfer_count, err_timeout);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic_ack();
    send(8'hA5, 8'd1);
    hold_cycles(9, 8'hA5);
    ack_step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || data_out !== 8'hA5 || xfer_count !== 8'd1) begin
      errors++;
      $display("FAIL basic_exit: ready=%b busy=%b data=%h cnt=%0d, required 1 0 a5 1",
               in_ready, busy, data_out, xfer_count);
    end
  endtask

  task automatic test_early_ack();
    send(8'h3C, 8'd2);
    hold_cycles(1, 8'h3C);
    ack_step();
    hold_cycles(4, 8'h3C);
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL early_ack_exit: busy=%b err=%b, required 0 0", busy, err_timeout);
    end
  endtask

  task automatic test_timeout();
    send(8'h11, 8'd3);
    hold_cycles(64, 8'h11);
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_exit: busy=%b err=%b, required 0 1", busy, err_timeout);
    end
    send(8'h22, 8'd4);
    hold_cycles(5, 8'h22);
    ack_step();
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: busy=%b err=%b, required 0 1", busy, err_timeout);
    end
  endtask

  task automatic test_enable_freeze();
    send(8'h44, 8'd5);
    hold_cycles(3, 8'h44);
    enaA = 1'b0;
    // An ack while disabled must not be remembered either.
    ack_in = 1'b1;
    hold_cycles(1, 8'h44);
    ack_in = 1'b0;
    hold_cycles(9, 8'h44);
    enaA = 1'b1;
    hold_cycles(6, 8'h44);
    ack_step();
    checks++;
    if (busy !== 1'b0 || xfer_count !== 8'd5 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL freeze_exit: busy=%b cnt=%0d err=%b, required 0 5 1",
               busy, xfer_count, err_timeout);
    end
  endtask

  task automatic test_back_to_back();
    ack_step();
    checks++;
    if (busy !== 1'b0 || xfer_count !== 8'd5) begin
      errors++;
      $display("FAIL stray_ack: busy=%b cnt=%0d, required 0 5", busy, xfer_count);
    end
    send(8'h81, 8'd6);
    hold_cycles(5, 8'h81);
    ack_step();
    send(8'h82, 8'd7);
    hold_cycles(5, 8'h82);
    ack_step();
    checks++;
    if (busy !== 1'b0 || data_out !== 8'h82) begin
      errors++;
      $display("FAIL b2b_exit: busy=%b data=%h, required 0 82", busy, data_out);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h55, 8'd8);
    hold_cycles(2, 8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || data_out !== 8'h00 || xfer_count !== 8'd0 || err_timeout !== 1'b0 ||
        pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b data=%h cnt=%0d err=%b pulse=%b, required 0 00 0 0 0",
               busy, data_out, xfer_count, err_timeout, pulse_out);
    end
    step();
    rst_n = 1'b1;
    send(8'h66, 8'd1);
    hold_cycles(5, 8'h66);
    ack_step();
  endtask

  task automatic test_ack_timeout_tie();
    send(8'h77, 8'd2);
    hold_cycles(63, 8'h77);
    ack_step();
    checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL ack_timeout_tie: busy=%b err=%b, required 0 0", busy, err_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_early_ack();
    test_timeout();
    test_enable_freeze();
    test_back_to_back();
    test_reset_mid();
    test_ack_timeout_tie();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
